// File: rtl/sram_flash_wb_ctrl_pkg.sv
// Shared types and constants for the SRAM/flash Wishbone bridge.
// Holds the FSM encoding, the pad strobe bundle and its idle value.
package sram_flash_wb_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_WREC = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    localparam logic [3:0] BW_IDLE   = 4'hf;
    localparam logic [3:0] BW_WORD   = 4'hc;
    localparam logic       TGA_SRAM  = 1'b0;
    localparam logic       TGA_FLASH = 1'b1;

    // Everything the pad stage registers besides address and data.
    typedef struct packed {
        logic       oe_n;
        logic       we_n;
        logic [3:0] bw;
        logic       cen;
        logic       ce2;
        logic       drive;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{1'b1, 1'b1, BW_IDLE, 1'b1, 1'b0, 1'b0};

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_flash_pad_drv.sv
// Pad stage: registers every pin output, drives the shared data bus
// and captures read data from it on request.
module sram_flash_pad_drv
    import sram_flash_wb_ctrl_pkg::*;
#(
    parameter int ADDR_W = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  strobe_t           strobe_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    input  logic              sample_i,
    input  logic              clear_i,
    output logic [15:0]       rdata_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              oe_n_o,
    output logic              we_n_o,
    output logic [3:0]        bw_o,
    output logic              cen_o,
    output logic              ce2_o,
    inout  wire  [15:0]       data_io
);

    strobe_t           strobe_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       rdata_q;
    logic [15:0]       rdata_d;

    // Sampling takes the bus value just before the edge that releases OE.
    always_comb begin
        rdata_d = rdata_q;
        if (sample_i) begin
            rdata_d = data_io;
        end else if (clear_i) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= STROBE_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            strobe_q <= strobe_i;
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            rdata_q  <= rdata_d;
        end
    end

    assign data_io = strobe_q.drive ? wdata_q : 16'hzzzz;
    assign rdata_o = rdata_q;
    assign addr_o  = addr_q;
    assign oe_n_o  = strobe_q.oe_n;
    assign we_n_o  = strobe_q.we_n;
    assign bw_o    = strobe_q.bw;
    assign cen_o   = strobe_q.cen;
    assign ce2_o   = strobe_q.ce2;

endmodule

// File: rtl/sram_flash_wb_ctrl.sv
// Wishbone classic slave turning 16-bit bus cycles into timed SRAM/flash
// pin accesses; pins lag the FSM state by one registered stage.
module sram_flash_wb_ctrl
    import sram_flash_wb_ctrl_pkg::*;
#(
    parameter int ADDR_W        = 21,
    parameter int SRAM_RD_WAIT  = 3,
    parameter int FLASH_RD_WAIT = 8,
    parameter int WR_WAIT       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    input  logic [1:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_tga_i,
    output logic              wb_ack_o,
    output logic              sram_clk_,
    output logic [ADDR_W-1:0] sram_flash_addr_,
    inout  wire  [15:0]       sram_flash_data_,
    output logic              sram_flash_oe_n_,
    output logic              sram_flash_we_n_,
    output logic [3:0]        sram_bw_,
    output logic              sram_cen_,
    output logic              flash_ce2_
);

    localparam int CNT_W = $clog2(max3(SRAM_RD_WAIT, FLASH_RD_WAIT, WR_WAIT)) + 1;
    localparam logic [CNT_W-1:0] SRAM_LOAD  = CNT_W'(SRAM_RD_WAIT - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WREC_LOAD  = CNT_W'((WR_WAIT > 0) ? WR_WAIT - 1 : 0);
    localparam logic [CNT_W-1:0] ACK_LOAD   = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [15:0]       dat_q, dat_d;
    logic [1:0]        sel_q, sel_d;
    logic              tga_q, tga_d;
    logic              we_q, we_d;
    logic              ack_q, ack_d;

    strobe_t           strobe_d;
    logic [ADDR_W-1:0] pin_addr_d;
    logic              sample;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        tga_d      = tga_q;
        we_d       = we_q;
        ack_d      = 1'b0;
        strobe_d   = STROBE_IDLE;
        pin_addr_d = '0;
        sample     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A still-high ack means the master has not yet seen it; its stb is stale.
                if (wb_cyc_i && wb_stb_i && !ack_q) begin
                    adr_d = wb_adr_i;
                    dat_d = wb_dat_i;
                    sel_d = wb_sel_i;
                    tga_d = wb_tga_i;
                    we_d  = wb_we_i;
                    if (!wb_we_i) begin
                        state_d = ST_RD;
                        cnt_d   = (wb_tga_i == TGA_FLASH) ? FLASH_LOAD : SRAM_LOAD;
                    end else if (wb_tga_i == TGA_SRAM) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_ACK;
                        cnt_d   = ACK_LOAD;
                    end
                end
            end
            ST_RD: begin
                strobe_d.oe_n = 1'b0;
                pin_addr_d    = adr_q;
                if (tga_q == TGA_FLASH) begin
                    strobe_d.ce2 = 1'b1;
                end else begin
                    strobe_d.cen = 1'b0;
                    strobe_d.bw  = BW_WORD;
                end
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    cnt_d   = ACK_LOAD;
                end
            end
            ST_WR: begin
                strobe_d.we_n  = 1'b0;
                strobe_d.cen   = 1'b0;
                strobe_d.bw    = {2'b11, ~sel_q};
                strobe_d.drive = 1'b1;
                pin_addr_d     = adr_q;
                if (WR_WAIT == 0) begin
                    state_d = ST_ACK;
                    cnt_d   = ACK_LOAD;
                end else begin
                    state_d = ST_WREC;
                    cnt_d   = WREC_LOAD;
                end
            end
            ST_WREC: begin
                strobe_d.cen   = 1'b0;
                strobe_d.drive = (cnt_q == WREC_LOAD);
                pin_addr_d     = adr_q;
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    cnt_d   = ACK_LOAD;
                end
            end
            ST_ACK: begin
                // First ACK cycle is the last edge the read strobes are still on the pins.
                sample = (cnt_q == ACK_LOAD) && !we_q;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    ack_d   = wb_cyc_i;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            tga_q   <= TGA_SRAM;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            tga_q   <= tga_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
        end
    end

    sram_flash_pad_drv #(
        .ADDR_W (ADDR_W)
    ) u_pad (
        .clk      (clk),
        .rst      (rst),
        .strobe_i (strobe_d),
        .addr_i   (pin_addr_d),
        .wdata_i  (dat_q),
        .sample_i (sample),
        .clear_i  (ack_q),
        .rdata_o  (wb_dat_o),
        .addr_o   (sram_flash_addr_),
        .oe_n_o   (sram_flash_oe_n_),
        .we_n_o   (sram_flash_we_n_),
        .bw_o     (sram_bw_),
        .cen_o    (sram_cen_),
        .ce2_o    (flash_ce2_),
        .data_io  (sram_flash_data_)
    );

    assign wb_ack_o  = ack_q;
    assign sram_clk_ = clk;

endmodule

// File: tb/tb_sram_flash_wb_ctrl.sv
// Bench: pin-level SRAM/flash environment plus a cycle-offset reference model
// derived from the access timing rules, checked every cycle.
module tb_sram_flash_wb_ctrl;

    localparam int ADDR_W = 21;
    localparam int SRW    = 3;
    localparam int FRW    = 8;
    localparam int WW     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] wb_adr_i = '0;
    logic [15:0]       wb_dat_i = '0;
    logic [1:0]        wb_sel_i = '0;
    logic              wb_we_i  = 1'b0;
    logic              wb_stb_i = 1'b0;
    logic              wb_cyc_i = 1'b0;
    logic              wb_tga_i = 1'b0;
    logic [15:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              sram_clk_;
    logic [ADDR_W-1:0] addr;
    wire  [15:0]       bus;
    logic              oe_n, we_n, cen, ce2;
    logic [3:0]        bw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_flash_wb_ctrl #(
        .ADDR_W(ADDR_W), .SRAM_RD_WAIT(SRW), .FLASH_RD_WAIT(FRW), .WR_WAIT(WW)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i), .wb_tga_i(wb_tga_i), .wb_ack_o(wb_ack_o),
        .sram_clk_(sram_clk_), .sram_flash_addr_(addr), .sram_flash_data_(bus),
        .sram_flash_oe_n_(oe_n), .sram_flash_we_n_(we_n), .sram_bw_(bw),
        .sram_cen_(cen), .flash_ce2_(ce2)
    );

    // ---------------- pin-level memory environment ----------------
    logic [15:0] pin_mem [0:255];
    logic [15:0] exp_mem [0:255];
    logic [15:0] env_rdata;
    logic        env_drv;

    function automatic logic [15:0] flash_word(input logic [ADDR_W-1:0] a);
        if (a == 21'h8) return 16'hCAFE;
        return {a[7:0], ~a[7:0]} ^ 16'h5A5A;
    endfunction

    always_comb begin
        env_drv   = !oe_n && we_n && (!cen || ce2);
        env_rdata = ce2 ? flash_word(addr) : pin_mem[addr[7:0]];
    end
    assign bus = env_drv ? env_rdata : 16'hzzzz;

    initial begin
        forever begin
            @(negedge clk);
            if (!we_n && !cen) begin
                if (!bw[0]) pin_mem[addr[7:0]][7:0]  = bus[7:0];
                if (!bw[1]) pin_mem[addr[7:0]][15:8] = bus[15:8];
            end
        end
    end

    // Pulse counters sampled mid-cycle, cleared by the main sequence.
    int we_low = 0, oe_low = 0, ack_cnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!we_n) we_low++;
            if (!oe_n) oe_low++;
            if (wb_ack_o) ack_cnt++;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit                m_busy = 0;
    int                m_k, m_lat;
    logic              m_we, m_tga;
    logic [ADDR_W-1:0] m_adr;
    logic [15:0]       m_dat, m_rd;
    logic [1:0]        m_sel;

    initial begin
        logic s_rst, s_cyc, s_stb;
        logic [28:0] e_pins, a_pins;
        logic e_oe, e_we, e_cen, e_ce2, e_drv, e_ack;
        logic [3:0] e_bw;
        logic [ADDR_W-1:0] e_addr;
        forever begin
            @(posedge clk);
            s_rst = rst; s_cyc = wb_cyc_i; s_stb = wb_stb_i;
            if (s_rst) begin
                m_busy = 0;
            end else if (m_busy) begin
                m_k++;
                if (m_k == m_lat + 1) m_busy = 0;
            end else if (s_cyc && s_stb) begin
                m_busy = 1; m_k = 0;
                m_we = wb_we_i; m_tga = wb_tga_i; m_adr = wb_adr_i;
                m_dat = wb_dat_i; m_sel = wb_sel_i;
                if (!m_we) m_lat = (m_tga ? FRW : SRW) + 2;
                else       m_lat = m_tga ? 2 : WW + 3;
                if (m_we && !m_tga) begin
                    if (m_sel[0]) exp_mem[m_adr[7:0]][7:0]  = m_dat[7:0];
                    if (m_sel[1]) exp_mem[m_adr[7:0]][15:8] = m_dat[15:8];
                end
                m_rd = m_tga ? flash_word(m_adr) : exp_mem[m_adr[7:0]];
            end

            e_oe = 1; e_we = 1; e_bw = 4'hf; e_cen = 1; e_ce2 = 0;
            e_addr = '0; e_drv = 0; e_ack = 0;
            if (m_busy) begin
                if (!m_we) begin
                    if (m_k >= 1 && m_k <= (m_tga ? FRW : SRW)) begin
                        e_oe = 0; e_addr = m_adr;
                        if (m_tga) e_ce2 = 1;
                        else begin e_cen = 0; e_bw = 4'hc; end
                    end
                end else if (!m_tga) begin
                    if (m_k == 1) begin
                        e_we = 0; e_cen = 0; e_bw = {2'b11, ~m_sel};
                        e_addr = m_adr; e_drv = 1;
                    end else if (m_k >= 2 && m_k <= WW + 1) begin
                        e_cen = 0; e_addr = m_adr; e_drv = (m_k == 2);
                    end
                end
                if (m_k == m_lat) e_ack = s_cyc;
            end

            #1;
            e_pins = {e_addr, e_oe, e_we, e_bw, e_cen, e_ce2};
            a_pins = {addr, oe_n, we_n, bw, cen, ce2};
            checks++;
            if (a_pins !== e_pins) begin
                errors++;
                $display("FAIL pins t=%0t got addr=%h oe=%b we=%b bw=%h cen=%b ce2=%b expected addr=%h oe=%b we=%b bw=%h cen=%b ce2=%b",
                         $time, addr, oe_n, we_n, bw, cen, ce2, e_addr, e_oe, e_we, e_bw, e_cen, e_ce2);
            end
            checks++;
            if (wb_ack_o !== e_ack) begin
                errors++;
                $display("FAIL ack t=%0t got %b expected %b", $time, wb_ack_o, e_ack);
            end
            if (e_ack && !m_we) begin
                checks++;
                if (wb_dat_o !== m_rd) begin
                    errors++;
                    $display("FAIL rdata t=%0t got %h expected %h", $time, wb_dat_o, m_rd);
                end
            end
            if (!m_busy) begin
                checks++;
                if (wb_dat_o !== 16'h0) begin
                    errors++;
                    $display("FAIL idle_dat t=%0t got %h expected 0000", $time, wb_dat_o);
                end
            end
            if (e_drv) begin
                checks++;
                if (bus !== m_dat) begin
                    errors++;
                    $display("FAIL bus t=%0t got %h expected %h", $time, bus, m_dat);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        @(negedge clk);
        we_low = 0; oe_low = 0; ack_cnt = 0;
    endtask

    // lat = cycles from accept edge to ack high, -1 if no ack within the budget.
    task automatic txn(input logic we, input logic tga, input logic [ADDR_W-1:0] adr,
                       input logic [15:0] dat, input logic [1:0] sel, input int hold,
                       input int drop_at, output int lat, output logic [15:0] rd);
        @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_tga_i = tga;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        lat = -1; rd = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (drop_at > 0 && c == drop_at) begin wb_cyc_i = 0; wb_stb_i = 0; end
            if (wb_ack_o) begin lat = c - 1; rd = wb_dat_o; break; end
        end
        if (drop_at == 0) begin
            checks++;
            if (lat < 0) begin
                errors++;
                $display("FAIL timeout adr=%h we=%b tga=%b got no ack expected ack", adr, we, tga);
            end
            repeat (hold) @(negedge clk);
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        $display("txn we=%b tga=%b adr=%h dat=%h sel=%b lat=%0d rd=%h", we, tga, adr, dat, sel, lat, rd);
    endtask

    initial begin
        int lat;
        logic [15:0] rd;
        for (int i = 0; i < 256; i++) begin
            pin_mem[i] = 16'(i * 257) ^ 16'h3C3C;
            exp_mem[i] = 16'(i * 257) ^ 16'h3C3C;
        end
        repeat (3) @(negedge clk);
        check_val("reset_pins", {addr, oe_n, we_n, bw, cen, ce2, wb_ack_o, wb_dat_o},
                  {21'h0, 1'b1, 1'b1, 4'hf, 1'b1, 1'b0, 1'b0, 16'h0});
        rst = 0;
        repeat (2) @(negedge clk);

        clear_counts();
        txn(1, 0, 21'h2, 16'h1234, 2'b11, 0, 0, lat, rd);
        check_val("wr_lat", lat, 5);
        check_val("wr_we_pulse", we_low, 1);

        clear_counts();
        txn(0, 0, 21'h2, 16'h0, 2'b00, 0, 0, lat, rd);
        check_val("rd_lat", lat, 5);
        check_val("rd_data", rd, 16'h1234);
        check_val("rd_oe_cycles", oe_low, 3);

        txn(1, 0, 21'h3, 16'h6789, 2'b11, 0, 0, lat, rd);
        txn(1, 0, 21'h3, 16'hAB00, 2'b10, 0, 0, lat, rd);
        txn(0, 0, 21'h3, 16'h0, 2'b00, 0, 0, lat, rd);
        check_val("byte_merge", rd, 16'hAB89);

        clear_counts();
        txn(0, 1, 21'h8, 16'h0, 2'b00, 0, 0, lat, rd);
        check_val("fl_rd_lat", lat, 10);
        check_val("fl_rd_data", rd, 16'hCAFE);
        check_val("fl_oe_cycles", oe_low, 8);

        clear_counts();
        txn(1, 1, 21'h8, 16'h5555, 2'b11, 0, 0, lat, rd);
        check_val("fl_wr_lat", lat, 2);
        check_val("fl_wr_no_we", we_low, 0);

        // Reset during the second RD pin cycle.
        clear_counts();
        @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_tga_i = 0; wb_adr_i = 21'h5;
        repeat (3) @(negedge clk);
        rst = 1; wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge clk);
        check_val("rst_abort_pins", {addr, oe_n, we_n, bw, cen, ce2},
                  {21'h0, 1'b1, 1'b1, 4'hf, 1'b1, 1'b0});
        rst = 0;
        repeat (8) @(negedge clk);
        check_val("rst_no_ack", ack_cnt, 0);
        txn(1, 0, 21'h6, 16'h0F0F, 2'b11, 0, 0, lat, rd);
        check_val("post_rst_wr_lat", lat, 5);

        // cyc dropped in the first WREC cycle.
        clear_counts();
        txn(1, 0, 21'h7, 16'hBEEF, 2'b11, 0, 3, lat, rd);
        check_val("drop_no_ack", lat, -1);
        check_val("drop_we_pulse", we_low, 1);
        check_val("drop_ack_cnt", ack_cnt, 0);
        txn(0, 0, 21'h7, 16'h0, 2'b00, 0, 0, lat, rd);
        check_val("drop_wr_landed", rd, 16'hBEEF);

        // stb kept high over the edge after ack.
        clear_counts();
        txn(0, 0, 21'h2, 16'h0, 2'b00, 1, 0, lat, rd);
        repeat (6) @(negedge clk);
        check_val("one_ack_per_accept", ack_cnt, 1);

        for (int n = 0; n < 40; n++) begin
            logic r_we, r_tga;
            r_we  = 1'($urandom_range(0, 1));
            r_tga = ($urandom_range(0, 3) == 0);
            txn(r_we, r_tga, ADDR_W'($urandom_range(0, 15)), 16'($urandom),
                2'($urandom_range(0, 3)), $urandom_range(0, 1), 0, lat, rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_flash_wb_ctrl.md
Name: sram_flash_wb_ctrl

Overview:
Wishbone classic slave that converts 16-bit CPU bus cycles into timed accesses on the board's shared SRAM/flash pin bus.
It sits directly upstream of the SRAM/flash pads: the CPU/Wishbone interconnect drives it, and it owns address, data, OE, WE, byte-write and chip-enable pins.
SRAM is read/write with byte lanes. Flash is read-only.

Parameters:
ADDR_W, 21, word address width on both the Wishbone and pin sides
SRAM_RD_WAIT, 3, cycles the SRAM read strobes are held before data is sampled (min 1)
FLASH_RD_WAIT, 8, cycles the flash read strobes are held before data is sampled (min 1)
WR_WAIT, 2, recovery cycles after the one-cycle WE pulse (min 0)

Ports:
clk  in  1  system clock; also forwarded to sram_clk_
rst  in  1  synchronous, active-high reset
wb_adr_i  in  ADDR_W  word address
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data, valid while wb_ack_o=1
wb_sel_i  in  2  byte lane enables; [0]=D[7:0], [1]=D[15:8]
wb_we_i  in  1  1=write
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_tga_i  in  1  region select: 1=flash, 0=SRAM
wb_ack_o  out  1  single-cycle acknowledge
sram_clk_  out  1  equals clk
sram_flash_addr_  out  ADDR_W  pin address, registered
sram_flash_data_  inout  16  shared data bus
sram_flash_oe_n_  out  1  output enable, active low
sram_flash_we_n_  out  1  write enable, active low
sram_bw_  out  4  SRAM byte writes, active low; [3:2] tied 2'b11
sram_cen_  out  1  SRAM chip enable, active low
flash_ce2_  out  1  flash chip enable, active high

Behaviour:
- All pin outputs and wb_ack_o are registered.
- Reset and IDLE values: oe_n=1, we_n=1, bw=4'hf, cen_=1, flash_ce2_=0, addr=0, ack=0, wb_dat_o=0, data bus Z.
- Reset mid-access aborts the access immediately. No ack is issued.
- FSM states: IDLE, RD, WR, WREC, ACK. A single wait counter is loaded on state entry.
- IDLE:
  - Accept when cyc&stb at edge N. Latch addr, data, sel and tga. Pins change at N+1.
  - Read -> RD. Write to SRAM -> WR. Write to flash -> ACK with no pin activity (discarded).
- RD:
  - Pins: oe_n=0, we_n=1.
  - SRAM: cen_=0, flash_ce2_=0, bw=4'hc.
  - Flash: cen_=1, flash_ce2_=1.
  - Held for SRAM_RD_WAIT or FLASH_RD_WAIT cycles. The data bus is sampled into wb_dat_o at the last of these edges, then -> ACK.
- WR: one cycle.
  - Pins: we_n=0, oe_n=1, cen_=0, bw={2'b11,~sel}.
  - Data bus driven with the write data.
  - -> WREC.
- WREC:
  - we_n=1, cen_=0; addr held.
  - Data driven only in the first WREC cycle (hold time), Z afterwards.
  - Held WR_WAIT cycles, then -> ACK. If WR_WAIT=0, go directly to ACK with no hold drive.
- ACK:
  - wb_ack_o=1 for exactly one cycle if cyc still high; if cyc has dropped, the ack is suppressed.
  - Strobes return to idle values. -> IDLE.
  - The next request cannot be accepted earlier than the cycle after ACK. No back-to-back reuse of a stale stb.
- Latency from accept edge to ack high:
  - SRAM read: SRAM_RD_WAIT+2 cycles.
  - Flash read: FLASH_RD_WAIT+2 cycles.
  - SRAM write: WR_WAIT+3 cycles.
  - Flash write: 2 cycles.
- sel=0 write: WE pulse still occurs, with bw=4'hf (no byte written).
- cyc dropping mid-access: the access completes on the pins and the ack is suppressed.
- Bus contention rule:
  - The data bus is driven only while oe_n=1.
  - The FPGA never drives the bus in RD or IDLE.
- Counter width: clog2(max wait)+1. No wrap; it counts down to 0.

Decomposition:
- Shared package:
  - State encoding constants.
  - Idle pin value constants (BW_IDLE=4'hf, BW_WORD=4'hc).
  - Region code constants (TGA_SRAM=0, TGA_FLASH=1).
- One natural sub-module: sram_flash_pad_drv, containing registered pin outputs plus the tristate data driver and input sample register.
- FSM and counter stay in the top module.

Test Plan:
- SRAM word write adr=21'h00002, dat=16'h1234, sel=2'b11, WR_WAIT=2 -> we_n low exactly 1 cycle, bw=4'hc, cen_=0, bus=16'h1234 for 2 cycles, ack 5 cycles after accept.
- SRAM read adr=21'h00002 (model returns 16'h1234), SRAM_RD_WAIT=3 -> oe_n low 3 cycles, cen_=0, flash_ce2_=0, bus never driven by DUT, wb_dat_o=16'h1234 with a 1-cycle ack 5 cycles after accept.
- Byte write sel=2'b10, dat=16'hAB00, to adr 3 over prior 16'h6789 -> bw=4'hd, then read back 16'hAB89.
- Flash read adr=21'h00008, tga=1 (model 16'hCAFE) -> cen_=1, flash_ce2_=1, oe_n low 8 cycles, ack with 16'hCAFE. Flash write -> no WE pulse, ack 2 cycles after accept.
- rst asserted in the 2nd RD cycle -> next edge shows all pins at idle values, no ack. A fresh SRAM write after reset release completes normally.
- cyc dropped during WREC -> write pulse completes, no ack. stb held high through ACK -> exactly one ack per accept.
